// File: rtl/cp0_timer_irq.sv
// CP0 timer and interrupt collection: Count with prescaler, NUM_CMP Compare
// channels, ext_int synchroniser, Cause.IP merge and registered int_req.

module cp0_cmp_chan (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic [31:0] count,
  output logic [31:0] compare,
  output logic        pend
);

  // A compare write beats a same-cycle match; the new value matches from next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      compare <= '0;
      pend    <= 1'b0;
    end else if (wr) begin
      compare <= wdata;
      pend    <= 1'b0;
    end else if (compare != '0 && count == compare) begin
      pend    <= 1'b1;
    end
  end

endmodule

module cp0_timer_irq #(
  parameter int NUM_CMP     = 1,
  parameter int COUNT_DIV   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               wen,
  input  logic [4:0]         addr,
  input  logic [2:0]         sel,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [5:0]         ext_int,
  input  logic [1:0]         sw_ip,
  input  logic [7:0]         status_im,
  input  logic               status_ie,
  input  logic               status_exl,
  output logic [7:0]         cause_ip,
  output logic [NUM_CMP-1:0] timer_pend,
  output logic               int_req,
  output logic [31:0]        count_out
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [31:0]                   count;
  logic [PW-1:0]                 presc;
  logic                          presc_wrap;
  logic                          cnt_wr;
  logic [NUM_CMP-1:0]            cmp_wr;
  logic [NUM_CMP-1:0][31:0]      compare;
  logic [SYNC_STAGES-1:0][5:0]   sync_q;
  logic [5:0]                    sync_int;

  assign cnt_wr     = wen && addr == 5'd9;
  assign presc_wrap = (presc == PW'(COUNT_DIV - 1));

  // A Count write restarts the prescaler so the next increment is a full period away.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      presc <= '0;
    end else if (cnt_wr) begin
      count <= wdata;
      presc <= '0;
    end else if (presc_wrap) begin
      count <= count + 32'd1;
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_CMP; i++) begin : g_cmp
      assign cmp_wr[i] = wen && addr == 5'd11 && sel == 3'(i);
      cp0_cmp_chan u_chan (
        .clk     (clk),
        .rst     (rst),
        .wr      (cmp_wr[i]),
        .wdata   (wdata),
        .count   (count),
        .compare (compare[i]),
        .pend    (timer_pend[i])
      );
    end
  endgenerate

  // Whole chain freezes on stall so the ext_int latency is counted in live cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else if (!stall) begin
      for (int s = SYNC_STAGES - 1; s > 0; s--)
        sync_q[s] <= sync_q[s-1];
      sync_q[0] <= ext_int;
    end
  end

  assign sync_int = sync_q[SYNC_STAGES-1];
  assign cause_ip = {sync_int[5] | (|timer_pend), sync_int[4:0], sw_ip};

  always_ff @(posedge clk) begin
    if (rst) int_req <= 1'b0;
    else     int_req <= status_ie & ~status_exl & (|(cause_ip & status_im));
  end

  always_comb begin
    rdata = '0;
    if (addr == 5'd9) begin
      rdata = count;
    end else if (addr == 5'd11) begin
      for (int k = 0; k < NUM_CMP; k++)
        if (sel == 3'(k)) rdata = compare[k];
    end
  end

  assign count_out = count;

endmodule

// File: doc/cp0_timer_irq.md
# cp0_timer_irq

Parametrised timer and interrupt-collection unit for the CP0 block of the pipelined MIPS core, sitting in the MEM stage beside the CP0 register file. It owns the Count register and up to four Compare channels, with a configurable count prescaler. It synchronises the external interrupt lines and merges them with timer and software interrupts into Cause.IP[7:0]. It then produces a registered, masked interrupt request for the exception logic.

## Interface
Parameters:
- NUM_CMP, default 1: number of Compare channels, 1..4. Compare sel 0..NUM_CMP-1 at CP0 reg 11.
- COUNT_DIV, default 2: clocks per Count increment, ≥1.
- SYNC_STAGES, default 2: synchroniser depth for ext_int, ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  pipeline stall; freezes the ext_int synchroniser chain.
- wen  in  1  mtc0 write enable.
- addr  in  5  CP0 register number for read/write.
- sel  in  3  CP0 select.
- wdata  in  32  mtc0 data.
- rdata  out  32  combinational read. Count (addr 9) or Compare[sel] (addr 11, sel<NUM_CMP); otherwise 0.
- ext_int  in  6  asynchronous hardware interrupt lines HW5..HW0.
- sw_ip  in  2  Cause.IP1..IP0 from the register file.
- status_im  in  8  Status.IM7..IM0.
- status_ie  in  1  Status.IE.
- status_exl  in  1  Status.EXL.
- cause_ip  out  8  merged Cause.IP7..IP0.
- timer_pend  out  NUM_CMP  per-channel timer pending flags.
- int_req  out  1  registered interrupt request.
- count_out  out  32  current Count.

## Operation
- Reset values:
  - count, prescaler, all compare[i], timer_pend, sync chain, int_req: 0.
  - cause_ip equals {0, 0, 0, 0, 0, 0, sw_ip}, i.e. only the software bits pass through.
- Prescaler:
  - Counts 0..COUNT_DIV-1.
  - On the wrap to 0, count increments by 1, modulo 2^32: 0xFFFF_FFFF wraps to 0.
- mtc0 Count (addr 9): loads count from wdata and clears the prescaler in the same edge; no increment occurs that edge.
- mtc0 Compare (addr 11, sel i<NUM_CMP): loads compare[i] and clears timer_pend[i].
  - Writes with sel≥NUM_CMP are ignored.
- Timer match:
  - timer_pend[i] sets when compare[i]≠0 and count==compare[i]. It is sticky.
  - It clears only by an mtc0 to compare[i] or by reset.
  - compare[i]==0 never matches.
- Simultaneous match and mtc0 Compare[i] in the same cycle: the write wins, so pend is cleared.
  - The new compare value is evaluated from the next cycle on.
- ext_int synchroniser:
  - SYNC_STAGES-deep flop chain per bit; the last stage is sync_int[5:0].
  - While stall=1, every stage holds its value.
- cause_ip:
  - ip[7] = sync_int[5] OR (OR of timer_pend).
  - ip[6:2] = sync_int[4:0].
  - ip[1:0] = sw_ip (combinational pass-through).
- int_req is a register, updated every cycle (independent of stall) to: status_ie AND NOT status_exl AND OR(cause_ip AND status_im).
- Reset mid-operation: all state returns to its reset value on the next edge; no pending survives.

## Timing
- Count with COUNT_DIV=N: after reset release, count reaches 1 at the N-th rising edge and then increments every N edges.
  - After an mtc0 Count of value V, count reaches V+1 N edges later.
- timer_pend[i] asserts one edge after the cycle in which count==compare[i].
- ext_int to cause_ip latency: SYNC_STAGES non-stalled edges.
- cause_ip to int_req latency: 1 edge.
- sw_ip to int_req latency: 1 edge.
- rdata is combinational from the current registers; an mtc0 becomes visible on rdata the cycle after the write.

## Test plan
- COUNT_DIV=2, release reset:
  - count_out reads 0,0,1,1,2 across edges 0..4.
  - mtc0 Count 0xFFFF_FFFF; two edges later count_out=0.
- NUM_CMP=2, compare[1]=5, COUNT_DIV=1:
  - timer_pend=2'b10 one edge after count==5; cause_ip[7]=1.
  - With im[7]=1, ie=1, exl=0: int_req=1 one edge later.
  - mtc0 compare[1] clears pend and int_req follows one edge later.
- compare[0]=0 while count passes 0 after wrap: timer_pend stays 0.
- mtc0 compare[0]=count value in the exact matching cycle: timer_pend[0] stays 0 that edge.
  - It sets next cycle only if count still equals the new value.
- SYNC_STAGES=2, pulse ext_int[2]=1:
  - cause_ip[4]=1 exactly 2 edges later.
  - Asserting stall for 3 cycles in between delays it by 3 edges.
  - With exl=1, int_req stays 0.
- Assert rst mid-run with pend set and count=0x1234: next edge count=0, timer_pend=0, int_req=0, cause_ip[7:2]=0.
